ps2_frame_rx: RTL and testbench
===============================

PS2_FRAME_RX -- requirements
Module: ps2_frame_rx

Interface
REQ-001 The block SHALL have these parameters, one per line: name, default, meaning.
- FILTER_LEN, 8, consecutive equal samples needed before the filtered PS/2 clock changes level.
- TIMEOUT_CYC, 100000, idle cycles between PS/2 clock falling edges that abort a frame in progress.

REQ-002 The block SHALL have these ports, one per line: name, direction, width, meaning.
- clk, in, 1, single system clock; all state is clocked on its rising edge.
- rst_n, in, 1, asynchronous active-low reset.
- ps2_clk, in, 1, raw PS/2 clock line, asynchronous to clk.
- ps2_data, in, 1, raw PS/2 data line, asynchronous to clk.
- rx_data, out, 8, last correctly received byte.
- rx_valid, out, 1, one-cycle pulse when rx_data is updated.
- rx_err, out, 1, one-cycle pulse when a frame is rejected.
- err_code, out, 2, reason for rejection: 1 = parity, 2 = framing, 3 = timeout; valid when rx_err = 1 and held until the next error.
- busy, out, 1, high while a frame is in progress.

Function
REQ-003 ps2_clk and ps2_data SHALL each pass through a 2-flop synchronizer before any other use.
REQ-004 The synchronized clock SHALL be glitch-filtered: the filtered level changes only after FILTER_LEN consecutive samples at the new level.
- A shorter pulse SHALL have no effect.
REQ-005 A falling edge of the filtered clock SHALL sample the synchronized data bit on that same clk cycle.
REQ-006 The state machine SHALL have three states: IDLE, RECV, DONE.
REQ-007 In IDLE, a falling edge with data = 0 (start bit) SHALL move the FSM to RECV with bit counter = 0.
- A falling edge with data = 1 SHALL be ignored, and the FSM stays in IDLE.
REQ-008 In RECV, each falling edge SHALL capture one bit, and the bit counter SHALL increment modulo its width.
- Bits 0-7 are data, LSB first, shifted into a holding register.
- Bit 8 is parity.
- Bit 9 is stop.
REQ-009 The falling edge that captures the stop bit SHALL move the FSM to DONE.
REQ-010 DONE SHALL last exactly one cycle, then return to IDLE.
REQ-011 In DONE, if the stop bit = 1 and the data bits plus the parity bit have odd total parity, the block SHALL:
- load rx_data;
- pulse rx_valid.
REQ-012 In DONE, if the stop bit = 0, the block SHALL pulse rx_err with err_code = 2.
REQ-013 In DONE, if the stop bit = 1 but parity fails, the block SHALL pulse rx_err with err_code = 1.
REQ-014 Framing error SHALL take priority over parity error.
REQ-015 rx_valid and rx_err SHALL never be high in the same cycle.
REQ-016 Latency: rx_valid or rx_err SHALL assert exactly 1 cycle after the clk cycle on which the stop-bit falling edge is detected.
REQ-017 A timeout counter SHALL run only in RECV and clear on every falling edge.
- On reaching TIMEOUT_CYC-1, the FSM SHALL return to IDLE, pulse rx_err with err_code = 3, and discard partial data.
- It SHALL saturate and never wrap.
REQ-018 If the timeout terminal count and a falling edge occur in the same cycle, the edge SHALL win and the timeout is not taken.
REQ-019 rx_data SHALL change only on a valid frame; error frames SHALL leave rx_data unchanged.
REQ-020 busy SHALL be 1 in RECV and DONE, and 0 in IDLE.
REQ-021 A falling edge arriving while in DONE SHALL be ignored.
- PS/2 timing makes this impossible for legal traffic.

Reset
REQ-022 On rst_n = 0, the block SHALL asynchronously set:
- FSM to IDLE;
- bit counter, timeout counter, holding register, rx_data and err_code to 0;
- rx_valid, rx_err and busy to 0;
- synchronizer and filter flops to 1 (idle line level).
REQ-023 Reset asserted mid-frame SHALL abandon the frame with no rx_valid or rx_err pulse.
- After release, reception resumes with the next start bit.

Structure
REQ-024 Package ps2_pkg SHALL hold the following, shared with the downstream decoder:
- FSM state enum;
- err_code enum (ERR_PARITY = 1, ERR_FRAME = 2, ERR_TIMEOUT = 3);
- constant FRAME_BITS = 11.
REQ-025 The synchronizer plus glitch filter SHALL be a sub-module, ps2_sync_filter, instantiated once per line.
- Its parameter is FILTER_LEN.
- Its outputs are the filtered level and the falling-edge pulse.

Verification
REQ-026 The bench SHALL cover these directed scenarios (ps2_clk period about 80 us):
- Send 0x1C with parity = 0 and stop = 1 -> one rx_valid pulse, rx_data = 0x1C, no rx_err.
- Send 0xF0 with parity = 1, then 0x1C -> two rx_valid pulses, rx_data = 0xF0 then 0x1C.
- Send 0x1C with parity = 1 -> rx_err with err_code = 1; rx_data keeps its prior value; no rx_valid.
- Send 0x1C with stop = 0 and bad parity -> rx_err with err_code = 2 (framing priority).
- Stop ps2_clk after 5 bits -> rx_err with err_code = 3 exactly TIMEOUT_CYC cycles after the last edge; busy = 0; the next full 0x1C frame is received correctly.
- Insert a 3-cycle low glitch on ps2_clk while idle, then assert rst_n = 0 mid-frame -> no pulses of any kind; outputs hold reset values; the following frame decodes correctly.

Source files
------------

// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared PS/2 receive types and constants
package ps2_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RECV = 2'd1,
    ST_DONE = 2'd2
  } ps2_state_e;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'd0,
    ERR_PARITY  = 2'd1,
    ERR_FRAME   = 2'd2,
    ERR_TIMEOUT = 2'd3
  } ps2_err_e;

  // start + 8 data + parity + stop
  localparam int FRAME_BITS = 11;
  localparam int BIT_CNT_W  = 4;

  // PS/2 uses odd parity over the data byte plus the parity bit
  function automatic logic frame_parity_ok(input logic [7:0] data, input logic par);
    return ^{data, par};
  endfunction

endpackage

// File: rtl/ps2_sync_filter.sv
// rtl/ps2_sync_filter.sv - 2-flop synchronizer plus glitch filter for one PS/2 line
module ps2_sync_filter
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic line_in,
  output logic level,
  output logic fall
);

  localparam int CNT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_LEN - 1);

  logic             sync_q1;
  logic             sync_q2;
  logic [CNT_W-1:0] cnt;

  // Bring the asynchronous line into the clk domain; idle line level is high
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q1 <= 1'b1;
      sync_q2 <= 1'b1;
    end else begin
      sync_q1 <= line_in;
      sync_q2 <= sync_q1;
    end
  end

  // Accept a new level only after FILTER_LEN consecutive samples agree; flag the high-to-low switch
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level <= 1'b1;
      cnt   <= '0;
      fall  <= 1'b0;
    end else begin
      fall <= 1'b0;
      if (sync_q2 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        level <= sync_q2;
        cnt   <= '0;
        fall  <= level;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/ps2_frame_rx.sv
// rtl/ps2_frame_rx.sv - PS/2 device-to-host frame receiver with parity, framing and timeout checks
module ps2_frame_rx
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_err,
  output logic [1:0] err_code,
  output logic       busy
);

  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

  logic clk_level;
  logic clk_fall;
  logic data_level;
  logic data_fall;
  logic unused_filt;

  ps2_state_e           state;
  logic [BIT_CNT_W-1:0] bit_cnt;
  logic [TMO_W-1:0]     tmo_cnt;
  logic [7:0]           shreg;
  logic                 par_bit;

  ps2_sync_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filt (
    .clk     (clk),
    .rst_n   (rst_n),
    .line_in (ps2_clk),
    .level   (clk_level),
    .fall    (clk_fall)
  );

  ps2_sync_filter #(.FILTER_LEN(FILTER_LEN)) u_data_filt (
    .clk     (clk),
    .rst_n   (rst_n),
    .line_in (ps2_data),
    .level   (data_level),
    .fall    (data_fall)
  );

  // Only the clock falling edge and the data level drive the receiver
  assign unused_filt = &{1'b0, clk_level, data_fall};

  // Frame FSM: outputs are decided on the stop-bit edge so they appear together with DONE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      bit_cnt  <= '0;
      tmo_cnt  <= '0;
      shreg    <= '0;
      par_bit  <= 1'b0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
      rx_err   <= 1'b0;
      err_code <= ERR_NONE;
      busy     <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      rx_err   <= 1'b0;
      case (state)
        ST_IDLE: begin
          tmo_cnt <= '0;
          if (clk_fall && !data_level) begin
            state   <= ST_RECV;
            bit_cnt <= '0;
            busy    <= 1'b1;
          end
        end
        ST_RECV: begin
          if (clk_fall) begin
            // an edge always beats a coincident terminal count
            tmo_cnt <= '0;
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt < BIT_CNT_W'(8)) begin
              shreg <= {data_level, shreg[7:1]};
            end else if (bit_cnt == BIT_CNT_W'(8)) begin
              par_bit <= data_level;
            end else begin
              state <= ST_DONE;
              if (!data_level) begin
                rx_err   <= 1'b1;
                err_code <= ERR_FRAME;
              end else if (!frame_parity_ok(shreg, par_bit)) begin
                rx_err   <= 1'b1;
                err_code <= ERR_PARITY;
              end else begin
                rx_data  <= shreg;
                rx_valid <= 1'b1;
              end
            end
          end else if (tmo_cnt == TMO_LAST) begin
            state    <= ST_IDLE;
            busy     <= 1'b0;
            bit_cnt  <= '0;
            shreg    <= '0;
            rx_err   <= 1'b1;
            err_code <= ERR_TIMEOUT;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        ST_DONE: begin
          // edges here are ignored; legal PS/2 timing cannot produce one
          state   <= ST_IDLE;
          busy    <= 1'b0;
          bit_cnt <= '0;
          tmo_cnt <= '0;
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_frame_rx.sv
// tb/tb_ps2_frame_rx.sv - scoreboard bench for ps2_frame_rx with random and directed frames
module tb_ps2_frame_rx;

  localparam int FL      = 8;
  localparam int TMO     = 400;
  localparam int HALF    = 20;
  // raw line fall -> 2 sync flops -> FL filter samples -> registered FSM output
  localparam int LAT     = FL + 3;
  localparam int LAT_TMO = FL + 3 + TMO;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_err;
  logic [1:0] err_code;
  logic       busy;

  typedef struct {
    bit         is_err;
    logic [7:0] data;
    logic [1:0] code;
    int         cyc;
  } exp_t;

  exp_t       exp_q[$];
  exp_t       mon_e;
  int         cyc = 0;
  int         checks = 0;
  int         errors = 0;
  logic [7:0] last_good = 8'h00;

  ps2_frame_rx #(.FILTER_LEN(FL), .TIMEOUT_CYC(TMO)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_err   (rx_err),
    .err_code (err_code),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every output pulse must match the next scoreboard entry
  always @(negedge clk) begin
    if (rx_valid && rx_err) begin
      checks++; errors++;
      $display("FAIL both_pulses cyc=%0d rx_valid=1 rx_err=1 required at most one", cyc);
    end else if (rx_valid || rx_err) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pulse cyc=%0d rx_valid=%0b rx_err=%0b code=%0d", cyc, rx_valid, rx_err, err_code);
      end else begin
        mon_e = exp_q.pop_front();
        if (rx_err !== mon_e.is_err) begin
          errors++;
          $display("FAIL pulse_kind cyc=%0d got rx_err=%0b required %0b", cyc, rx_err, mon_e.is_err);
        end
        checks++;
        if (rx_data !== mon_e.data) begin
          errors++;
          $display("FAIL rx_data cyc=%0d got %02h required %02h", cyc, rx_data, mon_e.data);
        end
        checks++;
        if (cyc != mon_e.cyc) begin
          errors++;
          $display("FAIL latency got cyc=%0d required cyc=%0d", cyc, mon_e.cyc);
        end
        if (mon_e.is_err) begin
          checks++;
          if (err_code !== mon_e.code) begin
            errors++;
            $display("FAIL err_code cyc=%0d got %0d required %0d", cyc, err_code, mon_e.code);
          end
        end
      end
    end
  end

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s got %02h required %02h", name, got, req);
    end
  endtask

  // Drive nbits of a frame; the expected outcome is queued as the last falling edge is driven
  task automatic send_frame(input logic [7:0] d, input bit par_flip, input bit stop_v,
                            input int nbits, input bit expect_it);
    logic [10:0] bits;
    logic        par;
    exp_t        e;
    par  = (~^d) ^ par_flip;
    bits = {stop_v, par, d, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      @(negedge clk) ps2_data = bits[i];
      repeat (HALF) @(negedge clk);
      ps2_clk = 1'b0;
      if (i == nbits - 1 && expect_it) begin
        if (nbits < 11) begin
          e = '{1'b1, last_good, 2'd3, cyc + LAT_TMO};
        end else if (!stop_v) begin
          e = '{1'b1, last_good, 2'd2, cyc + LAT};
        end else if ($countones({d, par}) % 2 == 1) begin
          last_good = d;
          e = '{1'b0, d, 2'd0, cyc + LAT};
        end else begin
          e = '{1'b1, last_good, 2'd1, cyc + LAT};
        end
        exp_q.push_back(e);
      end
      repeat (HALF) @(negedge clk);
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
    repeat (2 * HALF) @(negedge clk);
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < LAT_TMO + 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s missing %0d pulse(s) after %0d cycles", name, exp_q.size(), n);
      exp_q.delete();
    end
  endtask

  initial begin
    int r;
    logic [7:0] d;

    repeat (4) @(negedge clk);
    check("reset_rx_data", rx_data, 8'h00);
    check("reset_rx_valid", {7'd0, rx_valid}, 8'h00);
    check("reset_rx_err", {7'd0, rx_err}, 8'h00);
    check("reset_err_code", {6'd0, err_code}, 8'h00);
    check("reset_busy", {7'd0, busy}, 8'h00);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);

    send_frame(8'h1C, 1'b0, 1'b1, 11, 1'b1);
    drain("good_1c");
    send_frame(8'hF0, 1'b0, 1'b1, 11, 1'b1);
    send_frame(8'h1C, 1'b0, 1'b1, 11, 1'b1);
    drain("f0_then_1c");
    send_frame(8'h1C, 1'b1, 1'b1, 11, 1'b1);
    drain("parity_err");
    send_frame(8'h1C, 1'b1, 1'b0, 11, 1'b1);
    drain("frame_err");
    send_frame(8'h1C, 1'b0, 1'b1, 5, 1'b1);
    drain("timeout");
    check("busy_after_timeout", {7'd0, busy}, 8'h00);
    send_frame(8'h1C, 1'b0, 1'b1, 11, 1'b1);
    drain("after_timeout");

    // short low glitch with data held low would look like a start bit if it leaked through
    @(negedge clk) ps2_data = 1'b0;
    ps2_clk = 1'b0;
    repeat (3) @(negedge clk);
    ps2_clk = 1'b1;
    repeat (HALF) @(negedge clk);
    ps2_data = 1'b1;
    check("busy_after_glitch", {7'd0, busy}, 8'h00);

    send_frame(8'hA5, 1'b0, 1'b1, 4, 1'b0);
    check("busy_mid_frame", {7'd0, busy}, 8'h01);
    rst_n = 1'b0;
    #1;
    check("midrst_rx_data", rx_data, 8'h00);
    check("midrst_busy", {7'd0, busy}, 8'h00);
    check("midrst_err_code", {6'd0, err_code}, 8'h00);
    last_good = 8'h00;
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    repeat (LAT_TMO + 20) @(negedge clk);
    check("idle_after_reset", {7'd0, busy}, 8'h00);
    send_frame(8'h1C, 1'b0, 1'b1, 11, 1'b1);
    drain("after_reset");

    for (int k = 0; k < 14; k++) begin
      d = 8'($urandom_range(0, 255));
      r = $urandom_range(0, 9);
      if (r < 6)       send_frame(d, 1'b0, 1'b1, 11, 1'b1);
      else if (r < 8)  send_frame(d, 1'b1, 1'b1, 11, 1'b1);
      else if (r == 8) send_frame(d, 1'($urandom_range(0, 1)), 1'b0, 11, 1'b1);
      else             send_frame(d, 1'b0, 1'b1, $urandom_range(1, 10), 1'b1);
      drain("random");
    end

    repeat (20) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
